axi_lite_ram_ctrl: RTL and testbench
====================================

Name: axi_lite_ram_ctrl

Overview:
AXI4-Lite slave front-end that converts bus read/write transactions into single-cycle accesses on one port of the banked dual-port RAM. It sits between the system interconnect and RAM port A, with port B left to the local datapath. Write address and write data are captured independently, one transaction is in flight at a time, and reads and writes are arbitrated round-robin. Out-of-range addresses get an SLVERR response.

Parameters:
AXI_ADDR_WIDTH, 8, AXI byte-address width
RAM_ADDR_WIDTH, 5, RAM address width (RAM depth = 2**RAM_ADDR_WIDTH = 32)
DATA_WIDTH, 8, data width on AXI and RAM; one byte lane

Ports:
clka  input  1  single clock for the block and its RAM port
rsta  input  1  synchronous, active-high reset
s_axi_awaddr  input  AXI_ADDR_WIDTH  write address
s_axi_awvalid  input  1  write address valid
s_axi_awready  output  1  write address ready
s_axi_wdata  input  DATA_WIDTH  write data
s_axi_wstrb  input  1  byte strobe
s_axi_wvalid  input  1  write data valid
s_axi_wready  output  1  write data ready
s_axi_bresp  output  2  write response
s_axi_bvalid  output  1  write response valid
s_axi_bready  input  1  write response ready
s_axi_araddr  input  AXI_ADDR_WIDTH  read address
s_axi_arvalid  input  1  read address valid
s_axi_arready  output  1  read address ready
s_axi_rdata  output  DATA_WIDTH  read data
s_axi_rresp  output  2  read response
s_axi_rvalid  output  1  read data valid
s_axi_rready  input  1  read data ready
ram_en  output  1  RAM port enable
ram_we  output  1  RAM port write enable
ram_addr  output  RAM_ADDR_WIDTH  RAM port address
ram_din  output  DATA_WIDTH  RAM write data
ram_dout  input  DATA_WIDTH  RAM read data, valid 1 cycle after ram_en with ram_we=0

Behaviour:
- Clocking and reset: one clock (clka). Reset rsta is synchronous and active-high.
- Reset values: all outputs are 0 (all ready/valid signals, bresp, rresp, rdata, ram_en, ram_we, ram_addr, ram_din). The aw_got/w_got capture flags are cleared and the FSM returns to IDLE. The priority bit last_grant is set to READ, so the first write wins.
- Reset mid-operation: any in-flight transaction is dropped with no response. Any RAM access already issued still completes inside the RAM.
- FSM states: IDLE, WR_RAM, WR_RESP, RD_RAM, RD_CAP, RD_RESP.
- IDLE, write capture:
  - s_axi_awready = !aw_got && !rd_sel. On handshake, the address is registered and aw_got is set.
  - s_axi_wready = !w_got && !rd_sel. On handshake, wdata and wstrb are registered and w_got is set.
  - AW and W may complete in the same cycle or in either order, any number of cycles apart.
- IDLE, read selection:
  - rd_sel = arvalid && !aw_got && !w_got && (last_grant==WRITE || !(awvalid || wvalid)).
  - s_axi_arready = rd_sel. On handshake, araddr is registered, last_grant becomes READ, and the FSM goes to RD_RAM.
  - Once either write flag is set, reads are blocked until that write finishes.
- IDLE -> WR_RAM: on the edge where both aw_got and w_got become true (or already are). last_grant becomes WRITE.
- In-range test: address < 2**RAM_ADDR_WIDTH. ram_addr is the low RAM_ADDR_WIDTH bits of the AXI address.
- WR_RAM (1 cycle):
  - ram_en = in-range.
  - ram_we = in-range && wstrb.
  - ram_din = captured wdata.
  - Next state WR_RESP. Both flags clear.
- WR_RESP:
  - bvalid = 1.
  - bresp = 2'b10 if out of range, else 2'b00. A wstrb=0 write is OKAY with no RAM write.
  - Holds until bready, then returns to IDLE. bvalid deasserts on the cycle after the handshake.
- RD_RAM (1 cycle): ram_en = in-range, ram_we = 0. Next state RD_CAP.
- RD_CAP (1 cycle):
  - rdata <= in-range ? ram_dout : 0.
  - rresp <= in-range ? 2'b00 : 2'b10.
  - Next state RD_RESP.
- RD_RESP: rvalid = 1. rdata/rresp are held stable until rready, then the FSM returns to IDLE.
- Latency:
  - Write: bvalid is high 2 cycles after the last of the AW/W handshakes.
  - Read: rvalid is high 3 cycles after the AR handshake.
  - Back-to-back: 1 idle cycle between a response handshake and the next address acceptance.
- Arbitration: when AR and AW/W are valid in the same IDLE cycle, the direction not granted last wins. A partially captured write always completes before any read.
- ram_en/ram_we are high only in WR_RAM/RD_RAM and are never asserted together with a pending response.

Test Plan:
- Write 0xA5 to addr 0x07 with AW and W in the same cycle, bready=1; then read 0x07 -> ram_we pulse at addr 7; bvalid 2 cycles after the handshake, bresp=00; rdata=0xA5, rresp=00, rvalid 3 cycles after AR.
- W issued 4 cycles before AW (addr 0x1F, data 0x3C), arvalid held high throughout -> arready stays 0 until the write finishes; write commits first; then the read of 0x1F returns 0x3C.
- AR(0x02), AW and W all valid in the same cycle after reset -> write granted first; read granted next; with both types continuously valid, grants alternate W, R, W, R.
- Write addr 0x40 data 0xFF -> no ram_en; bresp=10. Read addr 0x80 -> rdata=0x00, rresp=10.
- wstrb=0 write of 0x11 to addr 0x05 that already holds 0x22 -> bresp=00; a following read returns 0x22.
- bready held low 5 cycles, then rsta pulsed for 1 cycle -> bvalid=0 on the next cycle; new AW/W are accepted in the first cycle after reset.

Source files
------------

// File: rtl/axi_lite_ram_ctrl.sv
// AXI4-Lite slave front-end for one port of a dual-port RAM.
// Write address and write data are captured independently. Only one
// transaction is in flight at a time. Reads and writes alternate when
// both are offered in the same idle cycle. Addresses beyond the RAM depth
// complete with SLVERR and never touch the RAM.
module axi_lite_ram_ctrl #(
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      clka,
  input  logic                      rsta,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic                      s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_din,
  input  logic [DATA_WIDTH-1:0]     ram_dout
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Direction that won the most recent arbitration.
  localparam logic GRANT_READ  = 1'b0;
  localparam logic GRANT_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR_RAM,
    WR_RESP,
    RD_RAM,
    RD_CAP,
    RD_RESP
  } state_t;

  state_t state;
  state_t state_next;

  // Write-capture flags and arbitration history.
  logic aw_got;
  logic w_got;
  logic last_grant;

  // One address register serves both directions. A read can only be
  // accepted when no write address is held, so the two never collide.
  logic [AXI_ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0]     cap_wdata;
  logic                      cap_wstrb;

  logic rd_sel;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic in_range;

  // True when the byte address maps onto a RAM word.
  function automatic logic addr_in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >> RAM_ADDR_WIDTH) == '0;
  endfunction

  assign aw_hs    = s_axi_awvalid && s_axi_awready;
  assign w_hs     = s_axi_wvalid && s_axi_wready;
  assign ar_hs    = s_axi_arvalid && s_axi_arready;
  assign in_range = addr_in_range(cap_addr);

  // Next-state, handshake readies, response flags and RAM strobes.
  // All of these are forced low while reset is asserted.
  always_comb begin
    state_next    = state;
    rd_sel        = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    s_axi_rvalid  = 1'b0;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_din       = '0;
    if (!rsta) begin
      case (state)
        IDLE: begin
          // A read wins only when no write is partially captured. It also
          // needs either the previous grant to have gone to a write, or no
          // write to be on offer this cycle.
          rd_sel = s_axi_arvalid && !aw_got && !w_got &&
                   (last_grant == GRANT_WRITE || !(s_axi_awvalid || s_axi_wvalid));
          s_axi_awready = !aw_got && !rd_sel;
          s_axi_wready  = !w_got && !rd_sel;
          s_axi_arready = rd_sel;
          if (rd_sel) begin
            state_next = RD_RAM;
          end else if ((aw_got || s_axi_awvalid) && (w_got || s_axi_wvalid)) begin
            state_next = WR_RAM;
          end
        end
        WR_RAM: begin
          ram_en     = in_range;
          ram_we     = in_range && cap_wstrb;
          ram_addr   = cap_addr[RAM_ADDR_WIDTH-1:0];
          ram_din    = cap_wdata;
          state_next = WR_RESP;
        end
        WR_RESP: begin
          s_axi_bvalid = 1'b1;
          s_axi_bresp  = in_range ? RESP_OKAY : RESP_SLVERR;
          if (s_axi_bready) begin
            state_next = IDLE;
          end
        end
        RD_RAM: begin
          ram_en     = in_range;
          ram_addr   = cap_addr[RAM_ADDR_WIDTH-1:0];
          state_next = RD_CAP;
        end
        RD_CAP: begin
          state_next = RD_RESP;
        end
        RD_RESP: begin
          s_axi_rvalid = 1'b1;
          if (s_axi_rready) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State register, capture flags, arbitration history and read response.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state       <= IDLE;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      last_grant  <= GRANT_READ;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else begin
      state <= state_next;
      if (aw_hs) begin
        aw_got <= 1'b1;
      end
      if (w_hs) begin
        w_got <= 1'b1;
      end
      if (ar_hs) begin
        last_grant <= GRANT_READ;
      end
      if (state == IDLE && state_next == WR_RAM) begin
        last_grant <= GRANT_WRITE;
      end
      if (state == WR_RAM) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      // RAM data is valid in the cycle after the RD_RAM enable.
      if (state == RD_CAP) begin
        s_axi_rdata <= in_range ? ram_dout : '0;
        s_axi_rresp <= in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Address and write-data capture. These are datapath registers, so they
  // are not reset. The readies are already low during reset.
  always_ff @(posedge clka) begin
    if (aw_hs) begin
      cap_addr <= s_axi_awaddr;
    end else if (ar_hs) begin
      cap_addr <= s_axi_araddr;
    end
    if (w_hs) begin
      cap_wdata <= s_axi_wdata;
      cap_wstrb <= s_axi_wstrb;
    end
  end

endmodule

// File: tb/tb_axi_lite_ram_ctrl.sv
// Bench for axi_lite_ram_ctrl. A simple RAM sits on the RAM port. A
// transaction-level model tracks memory contents, arbitration history and
// response timing, and is compared against the DUT on every falling edge.
module tb_axi_lite_ram_ctrl;

  logic       clk = 1'b0;
  logic       rsta;
  logic [7:0] awaddr;
  logic       awvalid;
  logic       awready;
  logic [7:0] wdata;
  logic       wstrb;
  logic       wvalid;
  logic       wready;
  logic [1:0] bresp;
  logic       bvalid;
  logic       bready;
  logic [7:0] araddr;
  logic       arvalid;
  logic       arready;
  logic [7:0] rdata;
  logic [1:0] rresp;
  logic       rvalid;
  logic       rready;
  logic       ram_en;
  logic       ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = 8'h00;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  axi_lite_ram_ctrl #(
    .AXI_ADDR_WIDTH(8),
    .RAM_ADDR_WIDTH(5),
    .DATA_WIDTH(8)
  ) dut (
    .clka(clk),
    .rsta(rsta),
    .s_axi_awaddr(awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bresp(bresp),
    .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_araddr(araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata(rdata),
    .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid),
    .s_axi_rready(rready),
    .ram_en(ram_en),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Synchronous RAM port: write-first is irrelevant, reads have one cycle latency.
  logic [7:0] ram [0:31] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      else        ram_dout <= ram[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] model_mem [0:31] = '{default: 8'h00};
  bit         grant_log [$];
  int         cyc = 0;
  bit         busy = 0, is_wr = 0, aw_cap = 0, w_cap = 0, last_wr = 0, prev_rst = 0;
  int         done_cyc = 0;
  logic [7:0] m_awaddr, m_wdata, op_addr, op_wdata, exp_rdata;
  logic       m_wstrb, op_wstrb;
  logic [1:0] exp_resp;
  bit         rd_pref, was_busy, exp_b, exp_r, exp_en, exp_we;

  function automatic bit in_rng(input logic [7:0] a);
    return a < 8'd32;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rsta) begin
      chk("reset_outputs", {awready, wready, arready, bvalid, rvalid, ram_en, ram_we,
                            ram_addr, ram_din, bresp}, 32'd0);
      busy = 0; aw_cap = 0; w_cap = 0; last_wr = 0; prev_rst = 1;
    end else begin
      if (prev_rst) chk("reset_rdata_rresp", {rdata, rresp}, 32'd0);
      prev_rst = 0;
      was_busy = busy;
      // Address/data acceptance: nothing while a transaction is in flight.
      // Otherwise a waiting read goes first only if no write is partially held
      // and writes either are not offered or had the previous grant.
      if (busy) begin
        chk("ready_while_busy", {awready, wready, arready}, 32'd0);
      end else begin
        rd_pref = arvalid && !aw_cap && !w_cap && (last_wr || !(awvalid || wvalid));
        chk("arbitration_ready", {awready, wready, arready},
            {29'd0, !aw_cap && !rd_pref, !w_cap && !rd_pref, rd_pref});
      end
      // Responses: write 2 cycles, read 3 cycles after the accepting cycle.
      exp_b = busy && is_wr && (cyc >= done_cyc + 2);
      exp_r = busy && !is_wr && (cyc >= done_cyc + 3);
      chk("bvalid", bvalid, exp_b);
      if (exp_b) chk("bresp", bresp, exp_resp);
      chk("rvalid", rvalid, exp_r);
      if (exp_r) chk("rdata_rresp", {rdata, rresp}, {exp_rdata, exp_resp});
      // RAM port: one access in the cycle after acceptance, in-range only.
      exp_en = busy && (cyc == done_cyc + 1) && in_rng(op_addr);
      exp_we = exp_en && is_wr && op_wstrb;
      chk("ram_en_we", {ram_en, ram_we}, {exp_en, exp_we});
      if (exp_en) chk("ram_addr", ram_addr, op_addr[4:0]);
      if (exp_we) chk("ram_din", ram_din, op_wdata);
      // Advance the model to reflect the coming clock edge.
      if (exp_b && bready) busy = 0;
      if (exp_r && rready) busy = 0;
      if (!was_busy) begin
        if (awvalid && awready) begin aw_cap = 1; m_awaddr = awaddr; end
        if (wvalid && wready) begin w_cap = 1; m_wdata = wdata; m_wstrb = wstrb; end
        if (arvalid && arready) begin
          busy = 1; is_wr = 0; done_cyc = cyc; last_wr = 0; op_addr = araddr;
          exp_rdata = in_rng(araddr) ? model_mem[araddr[4:0]] : 8'h00;
          exp_resp  = in_rng(araddr) ? 2'b00 : 2'b10;
          grant_log.push_back(1'b0);
        end
        if (aw_cap && w_cap) begin
          busy = 1; is_wr = 1; done_cyc = cyc; last_wr = 1; aw_cap = 0; w_cap = 0;
          op_addr = m_awaddr; op_wdata = m_wdata; op_wstrb = m_wstrb;
          exp_resp = in_rng(m_awaddr) ? 2'b00 : 2'b10;
          if (in_rng(m_awaddr) && m_wstrb) model_mem[m_awaddr[4:0]] = m_wdata;
          grant_log.push_back(1'b1);
        end
      end
    end
  end

  // ---------------- stimulus tasks (start and end at posedge+1) ----------------
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic s,
                          input int aw_dly, input int w_dly,
                          output logic [1:0] resp, output int ncyc);
    bit aw_done = 0, w_done = 0, b_done = 0;
    int n = 0;
    resp = 2'b11;
    while (!(aw_done && w_done) && n < 60) begin
      awaddr = a; wdata = d; wstrb = s;
      awvalid = !aw_done && (n >= aw_dly);
      wvalid  = !w_done && (n >= w_dly);
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge clk); #1;
      n++;
    end
    awvalid = 0; wvalid = 0;
    ncyc = n;
    chk("write_accepted", {aw_done, w_done}, 32'd3);
    n = 0;
    while (!b_done && n < 40) begin
      bready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (bvalid && bready) begin b_done = 1; resp = bresp; end
      @(posedge clk); #1;
      n++;
    end
    bready = 0;
    chk("write_response_seen", b_done, 32'd1);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] d, output logic [1:0] resp);
    bit ar_done = 0, r_done = 0;
    int n = 0;
    d = 8'h00; resp = 2'b11;
    araddr = a; arvalid = 1;
    while (!ar_done && n < 60) begin
      @(negedge clk);
      if (arready) ar_done = 1;
      @(posedge clk); #1;
      n++;
    end
    arvalid = 0;
    chk("read_accepted", ar_done, 32'd1);
    n = 0;
    while (!r_done && n < 40) begin
      rready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (rvalid && rready) begin r_done = 1; d = rdata; resp = rresp; end
      @(posedge clk); #1;
      n++;
    end
    rready = 0;
    chk("read_response_seen", r_done, 32'd1);
  endtask

  task automatic pulse_reset();
    rsta = 1;
    @(posedge clk); #1;
    rsta = 0;
  endtask

  // ---------------- directed and random sequences ----------------
  initial begin
    logic [1:0] br, br2, rr, rr2;
    logic [7:0] rd, rd2;
    int nc, base, sz;
    rsta = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    repeat (3) @(posedge clk);
    #1 rsta = 0;

    // Basic write then read
    do_write(8'h07, 8'hA5, 1'b1, 0, 0, br, nc);
    chk("t1_bresp", br, 32'd0);
    do_read(8'h07, rd, rr);
    chk("t1_rdata", {rd, rr}, {22'd0, 8'hA5, 2'b00});

    // W four cycles ahead of AW with a read waiting the whole time
    fork
      do_write(8'h1F, 8'h3C, 1'b1, 4, 0, br, nc);
      do_read(8'h1F, rd, rr);
    join
    sz = grant_log.size();
    chk("t2_write_before_read", {grant_log[sz-2], grant_log[sz-1]}, 32'b10);
    chk("t2_rdata", {rd, rr}, {22'd0, 8'h3C, 2'b00});

    // After reset, simultaneous requests alternate starting with a write
    pulse_reset();
    base = grant_log.size();
    fork
      begin
        do_write(8'h02, 8'h5A, 1'b1, 0, 0, br, nc);
        do_write(8'h03, 8'h66, 1'b1, 0, 0, br2, nc);
      end
      begin
        do_read(8'h02, rd, rr);
        do_read(8'h03, rd2, rr2);
      end
    join
    chk("t3_grant_count", grant_log.size() - base, 32'd4);
    chk("t3_grant_order", {grant_log[base], grant_log[base+1], grant_log[base+2],
                           grant_log[base+3]}, 32'b1010);
    chk("t3_read1", {rd, rr}, {22'd0, 8'h5A, 2'b00});
    chk("t3_read2", {rd2, rr2}, {22'd0, 8'h66, 2'b00});

    // Out-of-range accesses
    do_write(8'h40, 8'hFF, 1'b1, 0, 0, br, nc);
    chk("t4_write_slverr", br, 32'd2);
    do_read(8'h80, rd, rr);
    chk("t4_read_slverr", {rd, rr}, {22'd0, 8'h00, 2'b10});

    // Strobe-off write leaves memory untouched
    do_write(8'h05, 8'h22, 1'b1, 0, 0, br, nc);
    do_write(8'h05, 8'h11, 1'b0, 0, 0, br, nc);
    chk("t5_nostrb_bresp", br, 32'd0);
    do_read(8'h05, rd, rr);
    chk("t5_read_old", {rd, rr}, {22'd0, 8'h22, 2'b00});

    // Reset while a write response is stalled
    awaddr = 8'h09; wdata = 8'h77; wstrb = 1; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    chk("t6_accept", {awready, wready}, 32'b11);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("t6_bvalid_stalled", {bvalid, bresp}, 32'b100);
    @(posedge clk); #1;
    pulse_reset();
    fork
      do_write(8'h0A, 8'h5C, 1'b1, 0, 0, br, nc);
      begin @(negedge clk); chk("t6_bvalid_cleared", bvalid, 32'd0); end
    join
    chk("t6_first_cycle_accept", nc, 32'd1);
    do_read(8'h09, rd, rr);
    chk("t6_issued_write_kept", {rd, rr}, {22'd0, 8'h77, 2'b00});

    // Random concurrent traffic
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [7:0] a;
          logic [1:0] r;
          int c;
          a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_write(a, 8'($urandom), ($urandom_range(0, 4) != 0),
                   $urandom_range(0, 3), $urandom_range(0, 3), r, c);
        end
      end
      begin
        for (int j = 0; j < 60; j++) begin
          logic [7:0] a;
          logic [7:0] d;
          logic [1:0] r;
          a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_read(a, d, r);
        end
      end
    join

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
